// File: rtl/boot_bus_master_pkg.sv
// Shared types and defaults for the boot-memory loader: FSM states, default geometry.
package boot_bus_master_pkg;

  localparam int                BYTE_W         = 8;
  localparam int                DATA_W_DEF     = 16;
  localparam int                ADDR_W_DEF     = 4;
  localparam int                NWORDS_DEF     = 4;
  localparam logic [3:0]        BASE_ADDR_DEF  = 4'h7;

  typedef enum logic [3:0] {
    IDLE,
    RX_HI,
    RX_LO,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    RD_ADDR,
    RD_CMP,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/boot_bus_master_packer.sv
// Valid/ready byte-to-word assembler: high byte first, low byte completes the word.
// Opens for exactly one word per arm pulse and closes itself after the low byte.
module boot_byte_packer
  import boot_bus_master_pkg::*;
(
  input  logic              clk8th,
  input  logic              rst,
  input  logic              arm,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_byte,
  output logic              in_ready,
  output logic              hi_take,
  output logic              lo_take,
  output logic [15:0]       word
);

  logic              lo_phase;
  logic [BYTE_W-1:0] hi_byte;
  logic              take;

  assign take    = in_valid & in_ready;
  assign hi_take = take & ~lo_phase;
  assign lo_take = take & lo_phase;
  // The low byte is forwarded straight through so the FSM can capture the whole word on the handshake edge.
  assign word    = {hi_byte, in_byte};

  always_ff @(posedge clk8th or posedge rst) begin
    if (rst) begin
      in_ready <= 1'b0;
      lo_phase <= 1'b0;
      hi_byte  <= '0;
    end else if (arm) begin
      in_ready <= 1'b1;
      lo_phase <= 1'b0;
    end else if (hi_take) begin
      hi_byte  <= in_byte;
      lo_phase <= 1'b1;
    end else if (lo_take) begin
      in_ready <= 1'b0;
      lo_phase <= 1'b0;
    end
  end

endmodule

// File: rtl/boot_bus_master.sv
// Loads a big-endian byte stream into the boot memory, reads it back and reports done/error.
// Every bus output is a flop so the memory's gated write clock (we & cs) never sees a glitch.
module boot_bus_master
  import boot_bus_master_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_ADDR_DEF),
  parameter int                NWORDS    = NWORDS_DEF,
  parameter int                DATA_W    = DATA_W_DEF
) (
  input  logic              clk8th,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr
);

  localparam int               CNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NWORDS - 1);

  if (DATA_W != 16) begin : g_bad_data_w
    $error("boot_bus_master: DATA_W must be 16");
  end
  if (NWORDS < 1 || int'(BASE_ADDR) + NWORDS - 1 > (1 << ADDR_W) - 1) begin : g_bad_range
    $error("boot_bus_master: BASE_ADDR+NWORDS-1 exceeds the last writable word");
  end

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] buffer [NWORDS];

  logic              arm;
  logic              hi_take;
  logic              lo_take;
  logic [15:0]       word;
  logic              idle_like;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [CNT_W-1:0] c);
    return BASE_ADDR + ADDR_W'(c);
  endfunction

  assign idle_like = (state == IDLE) || (state == DONE) || (state == ERR);
  assign arm       = (idle_like && start) || (state == WR_HOLD && cnt != LAST);

  boot_byte_packer u_packer (
    .clk8th   (clk8th),
    .rst      (rst),
    .arm      (arm),
    .in_valid (in_valid),
    .in_byte  (in_byte),
    .in_ready (in_ready),
    .hi_take  (hi_take),
    .lo_take  (lo_take),
    .word     (word)
  );

  always_ff @(posedge clk8th or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      mem_cs   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_addr <= '0;
      for (int i = 0; i < NWORDS; i++) buffer[i] <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            done     <= 1'b0;
            error    <= 1'b0;
            err_addr <= '0;
            cnt      <= '0;
            cpu_hold <= 1'b1;
            state    <= RX_HI;
          end
        end
        RX_HI: begin
          if (hi_take) state <= RX_LO;
        end
        RX_LO: begin
          if (lo_take) begin
            buffer[cnt] <= DATA_W'(word);
            mem_cs      <= 1'b1;
            mem_we      <= 1'b0;
            mem_addr    <= word_addr(cnt);
            mem_din     <= DATA_W'(word);
            state       <= WR_SETUP;
          end
        end
        WR_SETUP: begin
          mem_we <= 1'b1;
          state  <= WR_STROBE;
        end
        WR_STROBE: begin
          // cs drops together with we; addr/din stay put for hold time.
          mem_we <= 1'b0;
          mem_cs <= 1'b0;
          state  <= WR_HOLD;
        end
        WR_HOLD: begin
          if (cnt == LAST) begin
            cnt      <= '0;
            mem_cs   <= 1'b1;
            mem_addr <= word_addr('0);
            mem_din  <= '0;
            state    <= RD_ADDR;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= RX_HI;
          end
        end
        RD_ADDR: begin
          state <= RD_CMP;
        end
        RD_CMP: begin
          if (mem_dout != buffer[cnt]) begin
            error    <= 1'b1;
            err_addr <= mem_addr;
            mem_cs   <= 1'b0;
            mem_addr <= '0;
            state    <= ERR;
          end else if (cnt == LAST) begin
            done     <= 1'b1;
            cpu_hold <= 1'b0;
            mem_cs   <= 1'b0;
            mem_addr <= '0;
            state    <= DONE;
          end else begin
            cnt      <= cnt + 1'b1;
            mem_addr <= word_addr(cnt + 1'b1);
            state    <= RD_ADDR;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
